spi_slave_ctrl: RTL

SPI mode-0 slave protocol engine that converts conditioned SPI pin activity into single-byte register-file reads and writes. It sits directly downstream of the input conditioners. It consumes the conditioned chip-select level, the conditioned MOSI level, and the one-cycle rising/falling-edge pulses of the conditioned SCLK. It drives MISO and a simple synchronous memory port.

---
 rtl/spi_slave_ctrl_if.sv | 27 ++
 rtl/spi_slave_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl_if.sv
`timescale 1ns/1ps
// SPI pin-side and register-file-side signals of the SPI slave protocol engine.
interface spi_slave_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  cs_n;
    logic                  mosi;
    logic                  sclk_pos;
    logic                  sclk_neg;
    logic                  miso;
    logic                  miso_oe;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cs_n, mosi, sclk_pos, sclk_neg, mem_rdata,
        output miso, miso_oe, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output cs_n, mosi, sclk_pos, sclk_neg, mem_rdata,
        input  miso, miso_oe, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/spi_slave_ctrl.sv
`timescale 1ns/1ps
// SPI mode-0 slave engine: header (address + R/W) then data bytes to/from a register file.
// Define SPI_AUTOINC_EN for unbounded bursts with wrapping address auto-increment.
module spi_slave_ctrl #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_ctrl_if.slave bus
);
    localparam int unsigned      CNT_W     = $clog2(ADDR_WIDTH + 2);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD_LOAD,
        RD_SHIFT,
        WR_DATA,
        WR_COMMIT,
        DONE
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [DATA_WIDTH-1:0] wdata, wdata_nxt;
    logic [DATA_WIDTH-1:0] tx_sr, tx_sr_nxt;
    logic                  is_rd, is_rd_nxt;
    logic                  miso, miso_nxt;
    logic                  miso_oe, miso_oe_nxt;
    logic                  mem_we, mem_we_nxt;
    logic                  pos_ok, neg_ok;

    // A deasserted chip select or simultaneous edges make an edge pulse void.
    assign pos_ok = bus.sclk_pos & ~bus.sclk_neg & ~bus.cs_n;
    assign neg_ok = bus.sclk_neg & ~bus.sclk_pos & ~bus.cs_n;

    assign bus.miso      = miso;
    assign bus.miso_oe   = miso_oe;
    assign bus.mem_addr  = addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr    <= '0;
            wdata   <= '0;
            tx_sr   <= '0;
            is_rd   <= 1'b0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            addr    <= addr_nxt;
            wdata   <= wdata_nxt;
            tx_sr   <= tx_sr_nxt;
            is_rd   <= is_rd_nxt;
            miso    <= miso_nxt;
            miso_oe <= miso_oe_nxt;
            mem_we  <= mem_we_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr;
        wdata_nxt = wdata;
        tx_sr_nxt = tx_sr;
        is_rd_nxt = is_rd;
        miso_nxt  = miso;

        case (state)
            IDLE: begin
                if (!bus.cs_n) state_nxt = HDR;
            end
            HDR: begin
                if (pos_ok) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == HDR_LAST) begin
                        is_rd_nxt = bus.mosi;
                        state_nxt = bus.mosi ? RD_LOAD : WR_DATA;
                    end else begin
                        addr_nxt = ADDR_WIDTH'({addr, bus.mosi});
                    end
                end
            end
            RD_LOAD: begin
                tx_sr_nxt = bus.mem_rdata;
                state_nxt = RD_SHIFT;
            end
            RD_SHIFT: begin
                if (neg_ok) begin
                    miso_nxt  = tx_sr[DATA_WIDTH-1];
                    tx_sr_nxt = DATA_WIDTH'({tx_sr, 1'b0});
                    cnt_nxt   = cnt + 1'b1;
                    if (cnt == DATA_LAST) begin
`ifdef SPI_AUTOINC_EN
                        addr_nxt  = addr + 1'b1;
                        state_nxt = RD_LOAD;
`else
                        state_nxt = DONE;
`endif
                    end
                end
            end
            WR_DATA: begin
                if (pos_ok) begin
                    wdata_nxt = DATA_WIDTH'({wdata, bus.mosi});
                    cnt_nxt   = cnt + 1'b1;
                    if (cnt == DATA_LAST) state_nxt = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                if (bus.cs_n) begin
                    state_nxt = IDLE;
                end else begin
`ifdef SPI_AUTOINC_EN
                    addr_nxt  = addr + 1'b1;
                    state_nxt = WR_DATA;
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE: begin
            end
            default: state_nxt = IDLE;
        endcase

        // Chip select release aborts everything except an already committed write.
        if (bus.cs_n && (state != WR_COMMIT)) state_nxt = IDLE;
        if (state_nxt != state) cnt_nxt = '0;
        if (state_nxt == IDLE) miso_nxt = 1'b0;

        miso_oe_nxt = ~bus.cs_n & ((state_nxt == RD_LOAD) || (state_nxt == RD_SHIFT) ||
                                   ((state_nxt == DONE) && is_rd_nxt));
        mem_we_nxt  = (state_nxt == WR_COMMIT);
    end
endmodule
